// File: rtl/traffic_phase_arbiter_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_arbiter_if
//
// Purpose : groups the request/enable inputs and the lamp/grant outputs of the
//           traffic phase arbiter into one bundle.
//
// Signals : go     - run enable, 0 freezes the arbiter
//           req    - level requests, bit0=HS1, bit1=HS2, bit2=FS1, bit3=FS2
//           grant  - one-hot owner of the current phase, 0 in all-red
//           hs1..fs2 - 2-bit light codes (red=10, green=00, yellow=01,
//                      redyellow=11)
//           busy   - high while a phase is in progress
//           emg, emgId - emergency preemption request and target approach,
//                        present only when EMERGENCY_PREEMPT_EN is defined
//
// Modports: master - the side driving go/req (sensors or testbench)
//           slave  - the arbiter itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface traffic_phase_arbiter_if;
   logic       go;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] hs1;
   logic [1:0] hs2;
   logic [1:0] fs1;
   logic [1:0] fs2;
   logic       busy;

`ifdef EMERGENCY_PREEMPT_EN
   logic       emg;
   logic [1:0] emgId;

   modport master (
      output go, req, emg, emgId,
      input  grant, hs1, hs2, fs1, fs2, busy
   );

   modport slave (
      input  go, req, emg, emgId,
      output grant, hs1, hs2, fs1, fs2, busy
   );
`else
   modport master (
      output go, req,
      input  grant, hs1, hs2, fs1, fs2, busy
   );

   modport slave (
      input  go, req,
      output grant, hs1, hs2, fs1, fs2, busy
   );
`endif
endinterface

// File: rtl/traffic_phase_arbiter.sv
// ---------------------------------------------------------------------------
// traffic_phase_arbiter
//
// Purpose : round-robin scheduler sharing the green phase of an intersection
//           between four approaches (HS1, HS2, FS1, FS2). The granted
//           approach is walked through red-yellow, green, yellow and an
//           all-red clearance; minimum and maximum green times are enforced
//           whenever another approach is waiting.
//
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset
//           bus    - traffic_phase_arbiter_if.slave (go, req in;
//                    grant, hs1, hs2, fs1, fs2, busy out)
//
// Options : EMERGENCY_PREEMPT_EN - when defined, bus.emg/bus.emgId let an
//           emergency vehicle cut the current phase short and take the next
//           one. Undefined by default.
//
// All T_* parameters must be at least 1 and at most 2^CNT_W-1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module traffic_phase_arbiter #(
   parameter int CNT_W       = 5,
   parameter int T_PREP      = 1,
   parameter int T_MIN_GREEN = 5,
   parameter int T_MAX_GREEN = 15,
   parameter int T_YELLOW    = 2,
   parameter int T_CLEAR     = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   traffic_phase_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ALLRED,
      PREP,
      GREEN,
      YELLOW
   } phaseState_t;

   localparam logic [1:0] LAMP_RED       = 2'b10;
   localparam logic [1:0] LAMP_GREEN     = 2'b00;
   localparam logic [1:0] LAMP_YELLOW    = 2'b01;
   localparam logic [1:0] LAMP_REDYELLOW = 2'b11;

   phaseState_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        win_q, win_d;
   logic              preempt_q, preempt_d;

   logic [3:0]        grant_q, grant_d;
   logic [3:0][1:0]   lamp_q, lamp_d;
   logic              busy_q, busy_d;

   logic              emgActive;
   logic [1:0]        emgId;
   logic [3:0]        otherReq;

`ifdef EMERGENCY_PREEMPT_EN
   assign emgActive = bus.emg;
   assign emgId     = bus.emgId;
`else
   assign emgActive = 1'b0;
   assign emgId     = 2'd0;
`endif

   // True once the state has been occupied for t GO-high edges counting the
   // one about to happen, i.e. cnt has reached t-1. Done in int so a
   // duration of 1 does not turn into an always-true unsigned compare.
   function automatic logic reached(input logic [CNT_W-1:0] c, input int t);
      return (int'(c) + 1) >= t;
   endfunction

   // First requesting approach found when searching ptr, ptr+1, ... mod 4.
   function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign otherReq = bus.req & ~(4'b0001 << win_q);

   // Next-state logic for the phase sequencer. Nothing moves while go is low,
   // so every register defaults to holding. Any state change restarts the
   // phase counter; otherwise it counts up and sticks at all-ones so an
   // uncontested green can be held forever without wrapping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      preempt_d = preempt_q;

      if (bus.go) begin
         cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

         case (state_q)
            ALLRED: begin
               if (reached(cnt_q, T_CLEAR) && (bus.req != 4'b0000 || emgActive)) begin
                  state_d   = PREP;
                  cnt_d     = '0;
                  win_d     = emgActive ? emgId : rrPick(bus.req, ptr_q);
                  preempt_d = emgActive;
               end
            end

            PREP: begin
               if (emgActive && win_q != emgId) begin
                  state_d = YELLOW;
                  cnt_d   = '0;
               end else if (reached(cnt_q, T_PREP)) begin
                  state_d = GREEN;
                  cnt_d   = '0;
               end
            end

            GREEN: begin
               if (emgActive && win_q != emgId) begin
                  state_d = YELLOW;
                  cnt_d   = '0;
               end else if (!emgActive && otherReq != 4'b0000) begin
                  if ((!bus.req[win_q] && reached(cnt_q, T_MIN_GREEN)) ||
                      ( bus.req[win_q] && reached(cnt_q, T_MAX_GREEN))) begin
                     state_d = YELLOW;
                     cnt_d   = '0;
                  end
               end
            end

            YELLOW: begin
               if (reached(cnt_q, T_YELLOW)) begin
                  state_d = ALLRED;
                  cnt_d   = '0;
                  if (!preempt_q) begin
                     ptr_d = win_q + 2'd1;
                  end
               end
            end

            default: begin
               state_d = ALLRED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Lamp/grant decode of the upcoming state so the outputs can be
   // registered alongside it and stay free of any path from req or go.
   always_comb begin
      busy_d  = (state_d != ALLRED);
      grant_d = busy_d ? (4'b0001 << win_d) : 4'b0000;
      lamp_d  = {4{LAMP_RED}};
      case (state_d)
         PREP:    lamp_d[win_d] = LAMP_REDYELLOW;
         GREEN:   lamp_d[win_d] = LAMP_GREEN;
         YELLOW:  lamp_d[win_d] = LAMP_YELLOW;
         default: lamp_d        = {4{LAMP_RED}};
      endcase
   end

   // State and output registers. Reset drops straight to all-red with no
   // yellow, which is the safe choice when the controller itself is reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ALLRED;
         cnt_q     <= '0;
         ptr_q     <= 2'd0;
         win_q     <= 2'd0;
         preempt_q <= 1'b0;
         grant_q   <= 4'b0000;
         lamp_q    <= {4{LAMP_RED}};
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         preempt_q <= preempt_d;
         grant_q   <= grant_d;
         lamp_q    <= lamp_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.hs1   = lamp_q[0];
   assign bus.hs2   = lamp_q[1];
   assign bus.fs1   = lamp_q[2];
   assign bus.fs2   = lamp_q[3];
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_arbiter
//
// Purpose : self-checking bench for traffic_phase_arbiter. Each scenario is a
//           table of per-cycle records {go, req, emg, expected outputs}
//           built from a phase/winner description; expected words are queued
//           when the inputs are driven and popped when the outputs are
//           sampled one time unit after the clock edge.
//
// Options : EMERGENCY_PREEMPT_EN adds the preemption scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_traffic_phase_arbiter;

   typedef enum {PH_AR, PH_PREP, PH_GREEN, PH_YELLOW} tbPhase_t;

   typedef struct {
      logic        go;
      logic [3:0]  req;
      logic        emg;
      logic [1:0]  emgId;
      logic [12:0] expected;
   } vector_t;

   logic clk;
   logic rstN;

   traffic_phase_arbiter_if bus ();

   traffic_phase_arbiter dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (bus)
   );

   vector_t     vectors[$];
   logic [12:0] scoreboard[$];
   int          testsRun    = 0;
   int          testsFailed = 0;
   logic        curEmg      = 1'b0;
   logic [1:0]  curEmgId    = 2'd0;

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {grant, hs1, hs2, fs1, fs2, busy} for a phase and its owner.
   function automatic logic [12:0] expectOut(input tbPhase_t ph, input logic [1:0] w);
      logic [1:0] lamp[4];
      logic [3:0] g;
      logic       b;
      for (int i = 0; i < 4; i++) lamp[i] = 2'b10;
      g = 4'b0000;
      b = 1'b0;
      if (ph != PH_AR) begin
         b = 1'b1;
         g = 4'b0001 << w;
         case (ph)
            PH_PREP:  lamp[w] = 2'b11;
            PH_GREEN: lamp[w] = 2'b00;
            default:  lamp[w] = 2'b01;
         endcase
      end
      return {g, lamp[0], lamp[1], lamp[2], lamp[3], b};
   endfunction

   function automatic logic [12:0] actualOut();
      return {bus.grant, bus.hs1, bus.hs2, bus.fs1, bus.fs2, bus.busy};
   endfunction

   // Appends n identical cycles to the vector table.
   task automatic addSteps(input logic go, input logic [3:0] req, input tbPhase_t ph,
                           input logic [1:0] w, input int n);
      vector_t v;
      v.go       = go;
      v.req      = req;
      v.emg      = curEmg;
      v.emgId    = curEmgId;
      v.expected = expectOut(ph, w);
      for (int i = 0; i < n; i++) vectors.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [12:0] exp);
      logic [12:0] act;
      act = actualOut();
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got grant/lamps/busy=%b expected %b", name, act, exp);
      end
   endtask

   // Plays the vector table one clock per record, then empties it.
   task automatic applyStimulus(input string label);
      for (int i = 0; i < vectors.size(); i++) begin
         bus.go  = vectors[i].go;
         bus.req = vectors[i].req;
`ifdef EMERGENCY_PREEMPT_EN
         bus.emg   = vectors[i].emg;
         bus.emgId = vectors[i].emgId;
`endif
         scoreboard.push_back(vectors[i].expected);
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s step %0d", label, i), scoreboard.pop_front());
      end
      vectors.delete();
   endtask

   // Asserts reset away from the clock edge, checks the all-red state
   // appears at once, and releases it on a falling edge.
   task automatic resetWith(input logic [3:0] req, input string label);
      @(negedge clk);
      #2;
      bus.go  = 1'b1;
      bus.req = req;
      rstN    = 1'b0;
      #1;
      checkOutput(label, expectOut(PH_AR, 2'd0));
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      rstN    = 1'b0;
      bus.go  = 1'b1;
      bus.req = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
      bus.emg   = 1'b0;
      bus.emgId = 2'd0;
`endif
      @(negedge clk);
      checkOutput("power-on reset", expectOut(PH_AR, 2'd0));

      // Single requester: green holds while uncontested, then hands over
      // through yellow and all-red to FS1 once HS1 drops its request.
      bus.req = 4'b0001;
      @(negedge clk);
      rstN = 1'b1;
      addSteps(1'b1, 4'b0001, PH_PREP,   2'd0, 1);
      addSteps(1'b1, 4'b0001, PH_GREEN,  2'd0, 41);
      addSteps(1'b1, 4'b0100, PH_YELLOW, 2'd0, 2);
      addSteps(1'b1, 4'b0100, PH_AR,     2'd0, 1);
      addSteps(1'b1, 4'b0100, PH_PREP,   2'd2, 1);
      addSteps(1'b1, 4'b0100, PH_GREEN,  2'd2, 3);
      applyStimulus("handover");

      // All four requesting: max-green rotation in pointer order, with a
      // ten-cycle freeze during the HS2 green.
      resetWith(4'b1111, "reset mid-green");
      for (int w = 0; w < 4; w++) begin
         addSteps(1'b1, 4'b1111, PH_PREP, 2'(w), 1);
         if (w == 1) begin
            addSteps(1'b1, 4'b1111, PH_GREEN, 2'(w), 3);
            addSteps(1'b0, 4'b1111, PH_GREEN, 2'(w), 10);
            addSteps(1'b1, 4'b1111, PH_GREEN, 2'(w), 12);
         end else begin
            addSteps(1'b1, 4'b1111, PH_GREEN, 2'(w), 15);
         end
         addSteps(1'b1, 4'b1111, PH_YELLOW, 2'(w), 2);
         addSteps(1'b1, 4'b1111, PH_AR,     2'(w), 1);
      end
      addSteps(1'b1, 4'b1111, PH_PREP,   2'd0, 1);
      addSteps(1'b1, 4'b1111, PH_GREEN,  2'd0, 3);
      addSteps(1'b1, 4'b1110, PH_GREEN,  2'd0, 2);
      addSteps(1'b1, 4'b1110, PH_YELLOW, 2'd0, 1);
      applyStimulus("roundRobin");

      // Reset while HS1 shows yellow: lamps go red at once, and the
      // restarted pointer search from HS1 lands on FS1.
      resetWith(4'b0100, "reset mid-yellow");
      addSteps(1'b1, 4'b0100, PH_PREP,  2'd2, 1);
      addSteps(1'b1, 4'b0100, PH_GREEN, 2'd2, 2);
      applyStimulus("afterReset");

`ifdef EMERGENCY_PREEMPT_EN
      // Emergency for FS2 cuts HS1 green at its first cycle; FS2 then holds
      // green while the emergency lasts, and the pointer left by HS1 (HS2)
      // is not advanced by the preempted FS2 phase.
      resetWith(4'b0001, "reset before preempt");
      addSteps(1'b1, 4'b0001, PH_PREP,  2'd0, 1);
      addSteps(1'b1, 4'b0001, PH_GREEN, 2'd0, 1);
      curEmg   = 1'b1;
      curEmgId = 2'd3;
      addSteps(1'b1, 4'b0001, PH_YELLOW, 2'd0, 2);
      addSteps(1'b1, 4'b0001, PH_AR,     2'd0, 1);
      addSteps(1'b1, 4'b0001, PH_PREP,   2'd3, 1);
      addSteps(1'b1, 4'b0001, PH_GREEN,  2'd3, 20);
      curEmg = 1'b0;
      addSteps(1'b1, 4'b0011, PH_YELLOW, 2'd3, 2);
      addSteps(1'b1, 4'b0011, PH_AR,     2'd3, 1);
      addSteps(1'b1, 4'b0011, PH_PREP,   2'd1, 1);
      addSteps(1'b1, 4'b0011, PH_GREEN,  2'd1, 2);
      applyStimulus("preempt");
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Safety net in case the run stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
